// File: rtl/breakout_pkg.sv
// Shared types and widths for the bus_breakout arbiter slice.
package breakout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // Native operand/result widths of the bus_breakout combine unit.
  localparam int unsigned BO_IN_W  = 4;
  localparam int unsigned BO_OUT_W = 6;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req scanning from ptr upward, wrapping at N-1.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [PW-1:0] idx
);

  // Scan N positions starting at ptr; the modulo handles non-power-of-2 N.
  always_comb begin
    logic [31:0] pos;
    gnt = '0;
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/breakout_arbiter.sv
// Round-robin arbiter sharing one external bus_breakout unit between NREQ requesters.
module breakout_arbiter
  import breakout_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IN_W  = BO_IN_W,
  parameter int unsigned OUT_W = BO_OUT_W,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][IN_W-1:0]  req_a,
  input  logic [NREQ-1:0][IN_W-1:0]  req_b,
  output logic [IN_W-1:0]            bo_in1,
  output logic [IN_W-1:0]            bo_in2,
  input  logic [OUT_W-1:0]           bo_out1,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [OUT_W-1:0]           rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       busy
);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [IN_W-1:0]  op_a_q, op_a_d;
  logic [IN_W-1:0]  op_b_q, op_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]  pick_gnt;
  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;

  rr_pick #(
    .N(NREQ)
  ) u_rr_pick (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .any(pick_any),
    .idx(pick_idx)
  );

  // Next-state, operand capture and response handshake.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        // No grant while reset is asserted, so no requester sees a phantom handshake.
        req_ready = pick_gnt & {NREQ{rst}};
        if (pick_any) begin
          op_a_d   = req_a[pick_idx];
          op_b_d   = req_b[pick_idx];
          rsp_id_d = pick_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = bo_out1;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Served requester drops to lowest priority; explicit wrap for non-power-of-2 NREQ.
          ptr_d   = (rsp_id_q == ID_W'(NREQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    bo_in1    = op_a_q;
    bo_in2    = op_b_q;
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_breakout_arbiter.sv
// Self-checking bench for breakout_arbiter with a behavioural bus_breakout stand-in.
module tb_breakout_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 6;
  localparam int unsigned ID_W  = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NREQ-1:0]           req_valid = '1;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][IN_W-1:0] req_a = '0;
  logic [NREQ-1:0][IN_W-1:0] req_b = '0;
  logic [IN_W-1:0]           bo_in1, bo_in2;
  logic [OUT_W-1:0]          bo_out1;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [OUT_W-1:0]          rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  always #5 clk = ~clk;

  // Combine function standing in for bus_breakout.
  function automatic logic [OUT_W-1:0] bo_fn(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    return ({2'b00, a} + {2'b00, b}) ^ {b[1:0], a};
  endfunction

  assign bo_out1 = bo_fn(bo_in1, bo_in2);

  breakout_arbiter #(
    .NREQ(NREQ),
    .IN_W(IN_W),
    .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .bo_in1(bo_in1),
    .bo_in2(bo_in2),
    .bo_out1(bo_out1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected {id, data} pushed at request handshake, popped at response handshake.
  logic [ID_W+OUT_W-1:0] sb_q[$];
  int                    grant_q[$];
  int                    rsp_cyc_q[$];
  int                    cyc = 0;
  bit                    hs_hit = 1'b0;
  int                    hs_idx = 0;
  bit                    hold_valid = 1'b0;

  always @(negedge clk) begin
    logic [ID_W+OUT_W-1:0] exp_e;
    cyc++;
    hs_hit = 1'b0;
    if (!rst) begin
      sb_q.delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_hit = 1'b1;
          hs_idx = i;
          sb_q.push_back({ID_W'(i), bo_fn(req_a[i], req_b[i])});
          grant_q.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc_q.push_back(cyc);
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          exp_e = sb_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(exp_e[OUT_W +: ID_W]));
          check("rsp_data", 32'(rsp_data), 32'(exp_e[OUT_W-1:0]));
        end
      end
    end
  end

  // Advance one cycle; requesters react to the handshake just taken (drop valid or reload).
  task automatic step();
    @(posedge clk);
    #1;
    if (hs_hit) begin
      if (hold_valid) begin
        req_a[hs_idx] = 4'($urandom_range(0, 15));
        req_b[hs_idx] = 4'($urandom_range(0, 15));
      end else begin
        req_valid[hs_idx] = 1'b0;
      end
    end
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 12 && !rsp_valid; i++) step();
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [OUT_W-1:0] exp_d;
    int pattern[6];
    pattern = '{0, 1, 2, 3, 0, 1};

    // Reset held with every requester valid.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bo_in1", 32'(bo_in1), 32'd0);
      check("rst_bo_in2", 32'(bo_in2), 32'd0);
    end
    rst       = 1'b1;
    req_valid = '0;
    step();

    // Single request from requester 2.
    req_a[2]  = 4'd3;
    req_b[2]  = 4'd9;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    step();
    check("single_exec_busy", 32'(busy), 32'd1);
    check("single_exec_rv", 32'(rsp_valid), 32'd0);
    check("single_exec_ready", 32'(req_ready), 32'd0);
    check("single_bo_in1", 32'(bo_in1), 32'd3);
    step();
    check("single_rv", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd2);
    check("single_data", 32'(rsp_data), 32'(bo_fn(4'd3, 4'd9)));
    step();
    check("single_idle", 32'(busy), 32'd0);

    // Wrap: pointer now 3, so 3 wins before 0.
    grant_q.delete();
    req_a[0]  = 4'($urandom_range(0, 15));
    req_b[0]  = 4'($urandom_range(0, 15));
    req_a[3]  = 4'($urandom_range(0, 15));
    req_b[3]  = 4'($urandom_range(0, 15));
    req_valid = 4'b1001;
    #1;
    check("wrap_ready", 32'(req_ready), 32'h8);
    repeat (8) step();
    check("wrap_ngrants", 32'(grant_q.size()), 32'd2);
    if (grant_q.size() >= 2) begin
      check("wrap_g0", 32'(grant_q[0]), 32'd3);
      check("wrap_g1", 32'(grant_q[1]), 32'd0);
    end

    // Return pointer to 0, then continuous requests from all four.
    rst = 1'b0;
    step();
    rst = 1'b1;
    grant_q.delete();
    rsp_cyc_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 4'($urandom_range(0, 15));
      req_b[i] = 4'($urandom_range(0, 15));
    end
    hold_valid = 1'b1;
    req_valid  = '1;
    repeat (18) step();
    hold_valid = 1'b0;
    req_valid  = '0;
    repeat (4) step();
    check("cont_ngrants_ge6", 32'(grant_q.size() >= 6), 32'd1);
    if (grant_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("cont_g%0d", i), 32'(grant_q[i]), 32'(pattern[i]));
    end
    if (rsp_cyc_q.size() >= 6) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("cont_gap%0d", i), 32'(rsp_cyc_q[i+1] - rsp_cyc_q[i]), 32'd3);
      end
    end

    // Backpressure on requester 1 (pointer is 2 after serving 1; scan 2,3,0,1 -> 1).
    rsp_ready = 1'b0;
    req_a[1]  = 4'($urandom_range(0, 15));
    req_b[1]  = 4'($urandom_range(0, 15));
    exp_d     = bo_fn(req_a[1], req_b[1]);
    req_valid = 4'b0010;
    wait_rsp("bp_rv_seen");
    req_a[2]     = 4'($urandom_range(0, 15));
    req_b[2]     = 4'($urandom_range(0, 15));
    req_valid[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rv", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(exp_d));
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_done_rv", 32'(rsp_valid), 32'd0);
    check("bp_done_busy", 32'(busy), 32'd0);
    check("bp_done_ready", 32'(req_ready), 32'h4);
    repeat (4) step();

    // Reset while a response waits unaccepted.
    rsp_ready = 1'b0;
    req_a[1]  = 4'($urandom_range(1, 15));
    req_b[1]  = 4'($urandom_range(1, 15));
    req_valid = 4'b0010;
    wait_rsp("mid_rv_seen");
    rst = 1'b0;
    step();
    check("mid_rv", 32'(rsp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_bo_in1", 32'(bo_in1), 32'd0);
    check("mid_bo_in2", 32'(bo_in2), 32'd0);
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    #1;
    check("mid_after_ready", 32'(req_ready), 32'h1);
    repeat (14) step();
    check("all_served", 32'(req_valid), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
